// File: rtl/ram_access_ctrl_if.sv
// Host-side command/response bundle for ram_access_ctrl.
// The host drives commands through master; the controller answers through slave.
interface ram_access_ctrl_if #(
  parameter int ADDR_W  = 5,
  parameter int WDATA_W = 3,
  parameter int RDATA_W = 9
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [WDATA_W-1:0] cmd_wdata;
  logic               rsp_valid;
  logic [ADDR_W-1:0]  rsp_addr;
  logic [RDATA_W-1:0] rsp_data;
  logic               rsp_last;
  logic               busy;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, busy
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// Sequences host read/write/scan commands into timed cycles for a synchronous RAM
// and returns read data as tagged one-cycle response pulses.
module ram_access_ctrl #(
  parameter int ADDR_W       = 5,
  parameter int WDATA_W      = 3,
  parameter int RDATA_W      = 9,
  parameter int READ_LATENCY = 1
) (
  input  logic               clock,
  input  logic               reset,
  ram_access_ctrl_if.slave   host,
  output logic [ADDR_W-1:0]  address,
  output logic               wren,
  output logic [WDATA_W-1:0] write,
  input  logic [RDATA_W-1:0] read
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, SCAN, DRAIN} state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SCAN  = 2'b10;

  state_t             state, state_next;
  logic [ADDR_W-1:0]  address_next;
  logic [WDATA_W-1:0] write_next;
  logic               wren_next;
  logic [ADDR_W-1:0]  scan_cnt, scan_cnt_next;
  logic               accept, issue, issue_last, drain_done;

  // Tag pipeline follows each issued address until its RAM data is valid;
  // together with the response register it is READ_LATENCY+1 stages deep.
  logic [READ_LATENCY-1:0] pipe_valid;
  logic [READ_LATENCY-1:0] pipe_last;
  logic [ADDR_W-1:0]       pipe_addr [READ_LATENCY];

  logic               rsp_valid;
  logic               rsp_last;
  logic [ADDR_W-1:0]  rsp_addr;
  logic [RDATA_W-1:0] rsp_data;

  assign host.cmd_ready = (state == IDLE) && !reset;
  assign host.busy      = (state != IDLE) || (|pipe_valid);
  assign host.rsp_valid = rsp_valid;
  assign host.rsp_last  = rsp_last;
  assign host.rsp_addr  = rsp_addr;
  assign host.rsp_data  = rsp_data;

  assign accept     = host.cmd_valid && host.cmd_ready;
  assign issue      = (state == READ) || (state == SCAN);
  assign issue_last = (state == READ) || ((state == SCAN) && (scan_cnt == '1));

  // Leave DRAIN on the edge that moves the final tag into the response register.
  always_comb begin
    drain_done = 1'b1;
    for (int k = 0; k < READ_LATENCY - 1; k++) begin
      if (pipe_valid[k]) drain_done = 1'b0;
    end
  end

  // NOTE: every signal gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_next    = state;
    address_next  = address;
    write_next    = write;
    wren_next     = 1'b0;
    scan_cnt_next = scan_cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (host.cmd_op)
            OP_WRITE: begin
              state_next   = WRITE;
              address_next = host.cmd_addr;
              write_next   = host.cmd_wdata;
              wren_next    = 1'b1;
            end
            OP_READ: begin
              state_next   = READ;
              address_next = host.cmd_addr;
            end
            OP_SCAN: begin
              state_next    = SCAN;
              address_next  = host.cmd_addr;
              scan_cnt_next = '0;
            end
            default: ;
          endcase
        end
      end
      WRITE: state_next = IDLE;
      READ:  state_next = DRAIN;
      SCAN: begin
        if (scan_cnt == '1) begin
          state_next = DRAIN;
        end else begin
          address_next  = address + ADDR_W'(1);
          scan_cnt_next = scan_cnt + ADDR_W'(1);
        end
      end
      DRAIN:   if (drain_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      address  <= '0;
      write    <= '0;
      wren     <= 1'b0;
      scan_cnt <= '0;
    end else begin
      state    <= state_next;
      address  <= address_next;
      write    <= write_next;
      wren     <= wren_next;
      scan_cnt <= scan_cnt_next;
    end
  end

  // NOTE: the tag array is only READ_LATENCY entries, so it is cleared on reset too.
  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_valid <= '0;
      pipe_last  <= '0;
      for (int k = 0; k < READ_LATENCY; k++) pipe_addr[k] <= '0;
      rsp_valid  <= 1'b0;
      rsp_last   <= 1'b0;
      rsp_addr   <= '0;
      rsp_data   <= '0;
    end else begin
      pipe_valid[0] <= issue;
      pipe_last[0]  <= issue_last;
      pipe_addr[0]  <= address;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
        pipe_last[k]  <= pipe_last[k-1];
        pipe_addr[k]  <= pipe_addr[k-1];
      end
      rsp_valid <= pipe_valid[READ_LATENCY-1];
      rsp_last  <= pipe_valid[READ_LATENCY-1] && pipe_last[READ_LATENCY-1];
      if (pipe_valid[READ_LATENCY-1]) begin
        rsp_addr <= pipe_addr[READ_LATENCY-1];
        rsp_data <= read;
      end
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench: two controllers (READ_LATENCY 1 and 2) on behavioural RAMs,
// compared cycle by cycle against a command-level reference model.
module tb_ram_access_ctrl;
  localparam int AW = 5, WW = 3, RW = 9, DEPTH = 32;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [RW-1:0] data;
    logic          last;
  } rsp_t;

  logic          clock, reset;
  logic          vld [2];
  logic [1:0]    op;
  logic [AW-1:0] caddr;
  logic [WW-1:0] cwdata;

  logic [AW-1:0] address0, address1;
  logic          wren0, wren1;
  logic [WW-1:0] write0, write1;
  logic [RW-1:0] read0, read1;

  logic [RW-1:0] ram0 [DEPTH];
  logic [RW-1:0] ram1 [DEPTH];
  logic [RW-1:0] fill_img [DEPTH];
  logic          fill_req;
  logic [RW-1:0] rd0, rd1a, rd1b;

  int            total, bad, cyc;
  int            ready_at [2];
  int            wr_cyc [2];
  int            nrsp [2];
  logic [RW-1:0] ref_mem [2][DEPTH];
  rsp_t          q0[$];
  rsp_t          q1[$];

  ram_access_ctrl_if #(.ADDR_W(AW), .WDATA_W(WW), .RDATA_W(RW)) h0 ();
  ram_access_ctrl_if #(.ADDR_W(AW), .WDATA_W(WW), .RDATA_W(RW)) h1 ();

  assign h0.cmd_valid = vld[0];
  assign h0.cmd_op    = op;
  assign h0.cmd_addr  = caddr;
  assign h0.cmd_wdata = cwdata;
  assign h1.cmd_valid = vld[1];
  assign h1.cmd_op    = op;
  assign h1.cmd_addr  = caddr;
  assign h1.cmd_wdata = cwdata;

  ram_access_ctrl #(.ADDR_W(AW), .WDATA_W(WW), .RDATA_W(RW), .READ_LATENCY(1)) dut0 (
    .clock(clock), .reset(reset), .host(h0),
    .address(address0), .wren(wren0), .write(write0), .read(read0));

  ram_access_ctrl #(.ADDR_W(AW), .WDATA_W(WW), .RDATA_W(RW), .READ_LATENCY(2)) dut1 (
    .clock(clock), .reset(reset), .host(h1),
    .address(address1), .wren(wren1), .write(write1), .read(read1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural RAMs: one and two registered read stages.
  always @(posedge clock) begin
    if (fill_req) begin
      for (int k = 0; k < DEPTH; k++) begin
        ram0[k] <= fill_img[k];
        ram1[k] <= fill_img[k];
      end
    end else begin
      if (wren0 === 1'b1) ram0[address0] <= {6'b0, write0};
      if (wren1 === 1'b1) ram1[address1] <= {6'b0, write1};
    end
    rd0  <= ram0[address0];
    rd1a <= ram1[address1];
    rd1b <= rd1a;
  end
  assign read0 = rd0;
  assign read1 = rd1b;

  function automatic int lat(int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic logic exp_ready(int d);
    return !reset && (cyc >= ready_at[d]);
  endfunction

  function automatic string tg(string s, int d);
    return $sformatf("%s%0d", s, d);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(int d, rsp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Reference model: what a command accepted at the edge just taken must produce.
  task automatic accept_cmd(int d);
    int   n0 = cyc;
    int   l  = lat(d);
    rsp_t e;
    case (op)
      2'b01: begin
        ref_mem[d][caddr] = {6'b0, cwdata};
        wr_cyc[d]   = n0;
        ready_at[d] = n0 + 1;
      end
      2'b00: begin
        e.cyc = n0 + 1 + l; e.addr = caddr; e.data = ref_mem[d][caddr]; e.last = 1'b1;
        push(d, e);
        ready_at[d] = e.cyc;
      end
      2'b10: begin
        for (int i = 0; i < DEPTH; i++) begin
          e.addr = AW'((int'(caddr) + i) % DEPTH);
          e.cyc  = n0 + 1 + l + i;
          e.data = ref_mem[d][e.addr];
          e.last = (i == DEPTH - 1);
          push(d, e);
        end
        ready_at[d] = n0 + l + DEPTH;
      end
      default: ready_at[d] = n0;
    endcase
  endtask

  task automatic check_dut(int d, logic rdy, logic bsy, logic we, logic rv,
                           logic [AW-1:0] ra, logic [RW-1:0] rd, logic rl);
    rsp_t h;
    bit   have = 0;
    check(tg("cmd_ready", d), rdy, exp_ready(d));
    check(tg("busy", d), bsy, cyc < ready_at[d]);
    check(tg("wren", d), we, cyc == wr_cyc[d]);
    if (d == 0 && q0.size() > 0 && q0[0].cyc == cyc) begin h = q0.pop_front(); have = 1; end
    if (d == 1 && q1.size() > 0 && q1[0].cyc == cyc) begin h = q1.pop_front(); have = 1; end
    if (have) begin
      check(tg("rsp_valid", d), rv, 1);
      check(tg("rsp_addr", d), ra, h.addr);
      check(tg("rsp_data", d), rd, h.data);
      check(tg("rsp_last", d), rl, h.last);
    end else begin
      check(tg("stray_rsp", d), rv, 0);
    end
    if (rv === 1'b1) nrsp[d]++;
  endtask

  task automatic step();
    logic r;
    logic acc [2];
    r = reset;
    for (int d = 0; d < 2; d++) acc[d] = vld[d] && exp_ready(d);
    @(posedge clock);
    #1;
    cyc++;
    if (r) begin
      q0.delete();
      q1.delete();
      for (int d = 0; d < 2; d++) begin ready_at[d] = 0; wr_cyc[d] = -100; end
    end else begin
      for (int d = 0; d < 2; d++) if (acc[d]) begin accept_cmd(d); vld[d] = 1'b0; end
    end
    check_dut(0, h0.cmd_ready, h0.busy, wren0, h0.rsp_valid, h0.rsp_addr, h0.rsp_data, h0.rsp_last);
    check_dut(1, h1.cmd_ready, h1.busy, wren1, h1.rsp_valid, h1.rsp_addr, h1.rsp_data, h1.rsp_last);
  endtask

  // Present a command to both controllers and hold it until each has taken it.
  task automatic issue(logic [1:0] o, logic [AW-1:0] a, logic [WW-1:0] w);
    int n = 0;
    op = o; caddr = a; cwdata = w;
    vld[0] = 1'b1; vld[1] = 1'b1;
    while ((vld[0] || vld[1]) && n < 300) begin step(); n++; end
    check("accept_timeout", n < 300, 1);
    vld[0] = 1'b0; vld[1] = 1'b0;
  endtask

  task automatic idle_wait();
    int n = 0;
    while (!(exp_ready(0) && exp_ready(1)) && n < 300) begin step(); n++; end
    check("idle_timeout", n < 300, 1);
  endtask

  task automatic fill(bit identity);
    for (int k = 0; k < DEPTH; k++) begin
      fill_img[k]   = identity ? RW'(k) : RW'($urandom_range(0, 511));
      ref_mem[0][k] = fill_img[k];
      ref_mem[1][k] = fill_img[k];
    end
  endtask

  initial begin
    int base, n;
    total = 0; bad = 0; cyc = 0;
    reset = 1'b1; vld[0] = 1'b0; vld[1] = 1'b0;
    op = '0; caddr = '0; cwdata = '0;
    nrsp[0] = 0; nrsp[1] = 0;
    ready_at[0] = 0; ready_at[1] = 0; wr_cyc[0] = -100; wr_cyc[1] = -100;

    fill(1'b0);
    fill_img[0] = 9'h1A5; ref_mem[0][0] = 9'h1A5; ref_mem[1][0] = 9'h1A5;
    fill_req = 1'b1;
    step(); step();
    fill_req = 1'b0;
    step();
    check("rst_address0", address0, 0);    check("rst_address1", address1, 0);
    check("rst_write0", write0, 0);        check("rst_write1", write1, 0);
    check("rst_rsp_addr0", h0.rsp_addr, 0); check("rst_rsp_addr1", h1.rsp_addr, 0);
    check("rst_rsp_data0", h0.rsp_data, 0); check("rst_rsp_data1", h1.rsp_data, 0);
    check("rst_rsp_last0", h0.rsp_last, 0); check("rst_rsp_last1", h1.rsp_last, 0);
    reset = 1'b0;
    step();

    // Single write: one wren cycle carrying address 13, data 5.
    issue(2'b01, 5'b01101, 3'b101);
    check("wr_address0", address0, 13); check("wr_address1", address1, 13);
    check("wr_write0", write0, 5);      check("wr_write1", write1, 5);
    check("wr_wren0", wren0, 1);        check("wr_wren1", wren1, 1);
    idle_wait();

    // Read of the preset word 0, then write/read-back at the top address.
    issue(2'b00, 5'd0, 3'd0);
    idle_wait();
    issue(2'b01, 5'd31, 3'b011);
    idle_wait();
    issue(2'b00, 5'd31, 3'd0);
    idle_wait();

    // Wrapping scan over an identity-filled memory.
    fill(1'b1);
    fill_req = 1'b1; step(); fill_req = 1'b0;
    base = nrsp[0];
    n    = nrsp[1];
    issue(2'b10, 5'd30, 3'd0);
    idle_wait();
    check("scan_count0", nrsp[0] - base, DEPTH);
    check("scan_count1", nrsp[1] - n, DEPTH);

    // Reset in the middle of a scan, after ten responses.
    base = nrsp[0];
    issue(2'b10, AW'($urandom), 3'd0);
    n = 0;
    while (nrsp[0] < base + 10 && n < 100) begin step(); n++; end
    check("rsp10_timeout", nrsp[0] >= base + 10, 1);
    reset = 1'b1;
    step();
    check("mid_rst_wren0", wren0, 0);           check("mid_rst_wren1", wren1, 0);
    check("mid_rst_rsp0", h0.rsp_valid, 0);     check("mid_rst_rsp1", h1.rsp_valid, 0);
    step();
    reset = 1'b0;
    step();
    check("post_rst_ready0", h0.cmd_ready, 1);  check("post_rst_ready1", h1.cmd_ready, 1);
    issue(2'b00, 5'd7, 3'd0);
    idle_wait();

    // Reserved op held while a scan runs; accepted only once each controller is idle.
    issue(2'b10, 5'd3, 3'd0);
    issue(2'b11, 5'd12, 3'd6);
    step(); step();
    issue(2'b00, 5'd9, 3'd0);
    idle_wait();

    // Randomised traffic, sometimes back to back, sometimes with idle gaps.
    for (int t = 0; t < 40; t++) begin
      logic [1:0] o;
      o = 2'($urandom_range(0, 3));
      if (o == 2'b10 && $urandom_range(0, 2) != 0) o = 2'b00;
      issue(o, AW'($urandom), WW'($urandom));
      if ($urandom_range(0, 1) == 1) idle_wait();
    end
    idle_wait();
    repeat (4) step();
    check("leftover_rsp", q0.size() + q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
